// File: rtl/eb_credit_rx_if.sv
// eb_credit_rx_if: bundles the two handshake sides of the credit receiver.
//   Link side (credit based, no ready):
//     t_0_data   - beat payload from the upstream transmitter
//     t_0_valid  - beat present; the transmitter has spent one credit
//     t_0_credit - one-cycle pulse returning one credit upstream
//   Output stream side (valid/ready):
//     i_0_data   - stream payload
//     i_0_valid  - stream valid
//     i_0_ready  - stream ready from the downstream eb stage
// Modports:
//   master - the environment: transmitter plus downstream consumer
//   slave  - the eb_credit_rx block itself
interface eb_credit_rx_if #(
  parameter int T_0_WIDTH = 8
);
  logic [T_0_WIDTH-1:0] t_0_data;
  logic                 t_0_valid;
  logic                 t_0_credit;
  logic [T_0_WIDTH-1:0] i_0_data;
  logic                 i_0_valid;
  logic                 i_0_ready;

  modport master (
    output t_0_data,
    output t_0_valid,
    input  t_0_credit,
    input  i_0_data,
    input  i_0_valid,
    output i_0_ready
  );

  modport slave (
    input  t_0_data,
    input  t_0_valid,
    output t_0_credit,
    output i_0_data,
    output i_0_valid,
    input  i_0_ready
  );
endinterface

// File: rtl/eb_credit_rx.sv
// eb_credit_rx: receive end of a credit-based link.
// Beats arriving on the link are stored in a DEPTH-entry FIFO and presented
// as a valid/ready stream. Each freed entry is returned upstream as one
// credit pulse; after reset DEPTH credits are issued on consecutive cycles.
//
// Parameters:
//   T_0_WIDTH - data width of link and output stream (must match link if)
//   DEPTH     - FIFO entries and total link credits, legal range 2..64
// Ports:
//   clk      - clock
//   reset    - synchronous active-high reset
//   link     - eb_credit_rx_if.slave (t_0_* link side, i_0_* stream side)
//   level    - current FIFO occupancy
//   overflow - sticky flag: a beat arrived while full with no pop
//
// Optional feature, macro EB_CREDIT_RX_BYPASS_EN:
//   defined   - when the FIFO is empty an arriving beat is shown on the
//               stream in the same cycle; if taken it never enters the FIFO
//   undefined - output comes only from storage, push-to-valid latency 1
module eb_credit_rx #(
  parameter int T_0_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  eb_credit_rx_if.slave              link,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  logic [T_0_WIDTH-1:0] mem [DEPTH];
  ptr_t                 wr_ptr;
  ptr_t                 rd_ptr;
  logic [LW-1:0]        level_q;
  logic [LW-1:0]        pend_q;
  logic                 credit_q;
  logic                 overflow_q;

  logic                 empty;
  logic                 full;
  logic                 pend_nz;
  logic                 out_valid;
  logic [T_0_WIDTH-1:0] out_data;
  logic                 pop;
  logic                 bypass_take;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 drop;

  // Binary pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == LW'(DEPTH));
    pend_nz = (pend_q != '0);
`ifdef EB_CREDIT_RX_BYPASS_EN
    out_valid   = !empty || link.t_0_valid;
    out_data    = empty ? link.t_0_data : mem[rd_ptr];
    bypass_take = empty && link.t_0_valid && link.i_0_ready;
`else
    out_valid   = !empty;
    out_data    = mem[rd_ptr];
    bypass_take = 1'b0;
`endif
    pop = out_valid && link.i_0_ready;
    // A bypassed beat is both pushed and popped, so the FIFO sees neither.
    fifo_pop = pop && !bypass_take;
    // When full, a push is only accepted into the slot a same-cycle pop frees.
    fifo_push = link.t_0_valid && !bypass_take && (!full || fifo_pop);
    drop      = link.t_0_valid && full && !fifo_pop;
  end

  // Storage needs no reset: entries are only read while level covers them.
  always_ff @(posedge clk) begin
    if (!reset && fifo_push) begin
      mem[wr_ptr] <= link.t_0_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      pend_q     <= LW'(DEPTH);
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (fifo_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      level_q <= level_q + LW'(fifo_push) - LW'(fifo_pop);
      // Every pop (bypassed or not) owes one credit; at most one is paid
      // back per cycle, so a pop during the reset burst just extends it.
      pend_q   <= pend_q + LW'(pop) - LW'(pend_nz);
      credit_q <= pend_nz;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign link.i_0_valid  = out_valid;
  assign link.i_0_data   = out_data;
  assign link.t_0_credit = credit_q;
  assign level           = level_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_eb_credit_rx.sv
// tb_eb_credit_rx: directed self-checking bench for eb_credit_rx
// (DEPTH=4, T_0_WIDTH=8). Accepted beats go into a scoreboard queue when
// driven; a negedge monitor compares every stream handshake against it.
module tb_eb_credit_rx;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);

  logic          clk;
  logic          reset;
  logic [LW-1:0] level;
  logic          overflow;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  sb[$];

  eb_credit_rx_if #(.T_0_WIDTH(W)) bus ();

  eb_credit_rx #(
    .T_0_WIDTH(W),
    .DEPTH    (D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .link    (bus.slave),
    .level   (level),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; optionally record
  // the beat as one the DUT must eventually deliver.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r, input bit keep);
    @(posedge clk);
    #1;
    bus.t_0_valid = v;
    bus.t_0_data  = d;
    bus.i_0_ready = r;
    if (v && keep) sb.push_back(d);
  endtask

  // Scoreboard monitor: every handshake must deliver the oldest kept beat.
  always @(negedge clk) begin
    if (!reset && bus.i_0_valid && bus.i_0_ready) begin
      if (sb.size() != 0) checkOutput("out_data", {24'h0, bus.i_0_data}, {24'h0, sb.pop_front()});
      else checkOutput("out_data_unexpected", {24'h0, bus.i_0_data}, 32'hDEAD_BEEF);
    end
  end

  initial begin
    int cnt;
    int rises;
    logic prev;

    reset         = 1'b1;
    bus.t_0_valid = 1'b0;
    bus.t_0_data  = '0;
    bus.i_0_ready = 1'b0;

    // Reset values and the initial credit burst.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_credit", 32'(bus.t_0_credit), 0);
    checkOutput("rst_valid", 32'(bus.i_0_valid), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("burst_pre", 32'(bus.t_0_credit), 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("burst_credit%0d", i), 32'(bus.t_0_credit), (i < 4) ? 1 : 0);
    end
    checkOutput("burst_level", 32'(level), 0);
    checkOutput("burst_overflow", 32'(overflow), 0);

    // Fill with the stream stalled, then drain.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("fill_level%0d", i), 32'(level), i);
      checkOutput($sformatf("fill_credit%0d", i), 32'(bus.t_0_credit), 0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_level", 32'(level), 4);
    checkOutput("full_valid", 32'(bus.i_0_valid), 1);
    checkOutput("full_head", 32'(bus.i_0_data), 32'h11);
    checkOutput("full_credit", 32'(bus.t_0_credit), 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 8'h00, (i < 4) ? 1'b1 : 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("drain_level%0d", i), 32'(level), (i < 4) ? 4 - i : 0);
      checkOutput($sformatf("drain_credit%0d", i), 32'(bus.t_0_credit), (i >= 2 && i <= 5) ? 1 : 0);
    end

    // Full with a simultaneous push and pop.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("pp_level_before", 32'(level), 4);
    checkOutput("pp_head", 32'(bus.i_0_data), 32'h11);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("pp_level%0d", i), 32'(level), 4 - i);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pp_level_end", 32'(level), 0);
    checkOutput("pp_overflow", 32'(overflow), 0);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Overflow: push while full and stalled; the beat must vanish.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h61 + i), 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ovf_before", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("ovf_flag%0d", i), 32'(overflow), 1);
      checkOutput($sformatf("ovf_level%0d", i), 32'(level), 4);
    end
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ovf_drained_level", 32'(level), 0);
    checkOutput("ovf_sticky", 32'(overflow), 1);
    checkOutput("ovf_sb_empty", 32'(sb.size()), 0);

    // Reset again; pops during the credit burst must extend it contiguously.
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst2_overflow", 32'(overflow), 0);
    checkOutput("rst2_level", 32'(level), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cnt   = 0;
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i < 2) ? 1'b1 : 1'b0, 8'(8'hC1 + i), 1'b1, 1'b1);
      @(negedge clk);
      if (bus.t_0_credit) cnt++;
      if (bus.t_0_credit && !prev) rises++;
      prev = bus.t_0_credit;
    end
    checkOutput("burst2_count", 32'(cnt), 6);
    checkOutput("burst2_runs", 32'(rises), 1);
    checkOutput("burst2_level", 32'(level), 0);

    // Single beat into an empty FIFO with the stream ready.
    cnt = 0;
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1);
    @(negedge clk);
    if (bus.t_0_credit) cnt++;
`ifdef EB_CREDIT_RX_BYPASS_EN
    checkOutput("byp_valid", 32'(bus.i_0_valid), 1);
    checkOutput("byp_data", 32'(bus.i_0_data), 32'hA5);
    checkOutput("byp_level", 32'(level), 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    if (bus.t_0_credit) cnt++;
    checkOutput("byp_level_next", 32'(level), 0);
    checkOutput("byp_valid_next", 32'(bus.i_0_valid), 0);
`else
    checkOutput("nobyp_valid", 32'(bus.i_0_valid), 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    if (bus.t_0_credit) cnt++;
    checkOutput("nobyp_valid_next", 32'(bus.i_0_valid), 1);
    checkOutput("nobyp_data_next", 32'(bus.i_0_data), 32'hA5);
    checkOutput("nobyp_level_next", 32'(level), 1);
`endif
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      if (bus.t_0_credit) cnt++;
    end
    checkOutput("single_credit_count", 32'(cnt), 1);
    checkOutput("single_level_end", 32'(level), 0);
    checkOutput("final_sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eb_credit_rx.md
Name: eb_credit_rx

Overview:
- Receive end of a credit-based link. Terminates it and re-presents the data as a valid/ready stream to the local elastic-buffer pipeline.
- The upstream transmitter sends a beat only while it holds a credit. There is no ready on the link side.
- The block stores beats in a DEPTH-entry FIFO and returns one credit pulse per entry freed.
- It sits at the far side of long or registered-only wires, feeding standard eb stages.

Parameters:
- T_0_WIDTH, 8, data width of the link and of the output stream.
- DEPTH, 4, FIFO entries; also the total number of credits on the link. Legal range 2..64.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- t_0_data  input  T_0_WIDTH  link data.
- t_0_valid  input  1  beat present; the transmitter has spent one credit.
- t_0_credit  output  1  one-cycle pulse; each pulse returns exactly one credit.
- i_0_data  output  T_0_WIDTH  output stream data.
- i_0_valid  output  1  output stream valid.
- i_0_ready  input  1  output stream ready.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  output  1  sticky error flag.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values:
  - i_0_valid=0, t_0_credit=0, level=0, overflow=0.
  - FIFO read/write pointers = 0.
  - Credit-pending counter pend = DEPTH.
- Reset mid-operation: all stored beats are discarded and all state returns to the reset values. Uncredited beats are lost. The transmitter must be reset in the same cycle.
- Push: a push occurs in every cycle with t_0_valid=1 and no reset. t_0_data is written at the write pointer.
- Pop: a pop occurs when i_0_valid && i_0_ready.
- Output stream:
  - i_0_valid = (level != 0). i_0_data = entry at the read pointer.
  - Both come from registered storage; no combinational path from t_0 to i_0.
  - Latency from push to i_0_valid is 1 cycle.
  - Once i_0_valid=1 it holds, with i_0_data stable, until the pop.
- Pointers: binary, wrap from DEPTH-1 to 0. DEPTH need not be a power of 2.
- level: level_next = level + push_accepted - pop.
- Full with simultaneous push and pop: the push is accepted, level is unchanged, and the data is written into the slot being freed by the pop.
- Overflow:
  - A push with level==DEPTH and no pop in the same cycle is a protocol violation.
  - The beat is dropped, and level and pointers are unchanged.
  - overflow is set to 1 on the next clock and stays set until reset.
  - A dropped beat does not generate a credit.
- Credit return:
  - t_0_credit (registered) = (pend != 0) in the previous cycle.
  - pend_next = pend + pop - (pend != 0). At most one credit is returned per cycle.
  - After reset deasserts, DEPTH initial pulses appear on consecutive cycles, starting 1 cycle after the first non-reset edge. The transmitter starts with 0 credits.
  - A pop during the initial burst increments pend; the pulse train lengthens with no gap.
  - Pop-to-credit latency is 1 cycle when pend==0.
- Invariant (no overflow): level + pend + transmitter-held credits + in-flight credits = DEPTH at all times. pend never exceeds DEPTH.
- Unknowns: t_0_data is don't-care when t_0_valid=0. No X may propagate to i_0_valid, t_0_credit or level.

Optional Feature:
- Macro: EB_CREDIT_RX_BYPASS_EN.
- Defined: zero-latency path.
  - When level==0 and t_0_valid=1, i_0_valid=1 and i_0_data=t_0_data combinationally in the same cycle.
  - If i_0_ready=1 in that cycle, the beat is consumed without a FIFO write. It counts as push+pop: level is unchanged and pend increments.
  - If i_0_ready=0, the beat is written to the FIFO normally.
- Undefined: no combinational t_0 to i_0 path; push-to-output latency is 1 cycle as above.

Test Plan (DEPTH=4, T_0_WIDTH=8):
- Initial credits: hold reset 2 cycles, then release with no traffic. Expect t_0_credit=1 for exactly 4 consecutive cycles starting 1 cycle after release, then 0; level=0; overflow=0.
- Fill and drain: i_0_ready=0, push 0x11,0x22,0x33,0x44 on consecutive cycles. Expect level=4, i_0_data=0x11, no extra credits. Then set i_0_ready=1: outputs 0x11..0x44 in order, 4 credit pulses each 1 cycle after its pop, level returns to 0.
- Full with simultaneous push and pop: level=4 with i_0_ready=1 and push 0x55. Expect 0x11 popped, level stays 4, 0x55 emerges 4th, overflow=0.
- Overflow: level=4, i_0_ready=0, push 0x99. Expect overflow=1 next cycle, level=4, 0x99 never output, overflow stays 1 until reset.
- Pops during initial burst: push and pop 2 beats while the reset credit burst is running. Expect 6 contiguous credit pulses total.
- Bypass (macro defined): level=0, i_0_ready=1, push 0xA5. Expect i_0_valid=1 and i_0_data=0xA5 in the same cycle, level stays 0, credit pulse next cycle. With the macro undefined, 0xA5 appears 1 cycle later.
